minc_prog_loader: RTL and testbench
===================================

Name: minc_prog_loader

Overview:
- Upstream stage of the minc core.
- Receives a byte stream over a valid/ready handshake and assembles 9-bit instruction words (bit 8 = ADD/LD select, bits 7:0 = immediate).
- Writes the words into the core's 256x9 program memory.
- Holds the core in reset while loading, and releases it after a good frame.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1024, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- mem_we  out  1  program-memory write strobe, one cycle per word.
- mem_addr  out  8  write address.
- mem_wdata  out  9  instruction word.
- cpu_hold  out  1  drives the core's reset; 1 = core held.
- load_done  out  1  one-cycle pulse when a frame completes without error.
- load_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0.
  - FSM=IDLE; timeout counter=0.
- Frame format: SYNC_BYTE, ADDR, COUNT (0 means 256 words), then COUNT words sent as LO byte followed by HI byte, then CHK if LOADER_CHECKSUM_EN is defined.
- FSM states: IDLE, ADDR, COUNT, LO, HI, WR, CHK, ERR.
  - IDLE: bytes other than SYNC_BYTE are consumed and ignored. SYNC_BYTE -> ADDR, sets cpu_hold=1 and clears load_err.
  - ADDR: latch the byte into the address register -> COUNT.
  - COUNT: latch the byte into the 9-bit remaining counter (0 maps to 256) -> LO.
  - LO: latch the byte as word[7:0] -> HI.
  - HI: check the byte. bits[7:1] must be 0, otherwise -> ERR. Otherwise word[8]=bit0 -> WR.
  - WR: lasts exactly one cycle. in_ready=0. mem_we=1 with mem_addr=address register and mem_wdata=word, all registered outputs. Then the address increments modulo 256 (0xFF wraps to 0x00) and remaining decrements. If remaining is now 0 -> CHK when the macro is defined, else -> IDLE with load_done. Otherwise -> LO.
  - ERR: load_err=1 and cpu_hold stays 1. Bytes are consumed. SYNC_BYTE restarts the frame (-> ADDR). Any other byte is ignored.
- Successful completion: cpu_hold drops to 0 and load_done pulses, both in the same cycle as the transition to IDLE.
- in_ready: 1 in every state except WR. Throughput is 3 cycles per word when in_valid is held high.
- Timeout: the counter counts cycles with no accepted byte while in ADDR, COUNT, LO, HI or CHK, and clears on every accepted byte. When it reaches TIMEOUT_CYCLES -> ERR.
- Memory is not rolled back on error. Words already written remain in memory.
- RESET asserted mid-frame: in the next cycle every output returns to its reset value. A partial frame is discarded and no further writes occur.
- A SYNC_BYTE value appearing inside a frame is treated as data, not as a restart.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running 8-bit sum accumulates ADDR, COUNT and every LO/HI byte, modulo 256.
  - The CHK byte must make (sum + CHK) mod 256 == 0. Match -> IDLE, load_done pulse, cpu_hold=0. Mismatch -> ERR.
  - The timeout also applies while waiting for CHK.
- LOADER_CHECKSUM_EN undefined: no CHK state and no sum register. The frame ends after the last WR.

Test Plan:
- Reset, then idle with in_valid=0 -> cpu_hold=1, mem_we=0, load_err=0, in_ready=1.
- Stream A5,10,02,34,01,56,00 (checksum on: add 63), in_valid held high -> write 0x10<=0x134, then 0x11<=0x056; load_done pulses once; cpu_hold=0 afterwards.
- Stream A5,FF,02,01,00,02,01 (checksum on: add FB) -> writes 0xFF<=0x001, then 0x00<=0x102 (address wrap); load_done pulses.
- Stream A5,00,01,07,02 -> HI byte invalid; load_err=1, cpu_hold=1, no write. A following A5 clears load_err.
- Checksum on: stream A5,10,01,34,01,00 (bad CHK; correct value BA) -> write 0x10<=0x134 occurs; load_err=1; load_done never pulses; cpu_hold=1.
- Stream A5,20 then in_valid=0 for TIMEOUT_CYCLES -> ERR, load_err=1. Separately, RESET asserted mid-frame -> all outputs return to reset values in the next cycle.

Source files
------------

// File: rtl/minc_prog_loader_if.sv
// minc_prog_loader_if
// Purpose : groups the byte-stream handshake and the program-memory write
//           port of the minc program loader into one bundle.
// Signals : in_data/in_valid/in_ready - byte stream, transfer on valid&&ready
//           mem_we/mem_addr/mem_wdata  - 256x9 program memory write port
//           cpu_hold                   - core reset (1 = held)
//           load_done                  - one-cycle pulse on a good frame
//           load_err                   - sticky error flag
// Modports: slave  - the loader itself
//           master - the stream source / memory / core side
interface minc_prog_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/minc_prog_loader.sv
// minc_prog_loader
// Purpose : receives framed bytes (SYNC, ADDR, COUNT, COUNT x {LO,HI}[, CHK]),
//           assembles 9-bit instruction words and writes them into the minc
//           program memory, holding the core in reset while loading.
// Ports   : CLK   - system clock, rising edge
//           RESET - synchronous, active-high reset
//           bus   - minc_prog_loader_if.slave (stream in, memory write out,
//                   cpu_hold / load_done / load_err status)
// Option  : LOADER_CHECKSUM_EN - when defined, a trailing CHK byte must make
//           the 8-bit sum of ADDR, COUNT and all data bytes equal zero.
// Params  : SYNC_BYTE      - frame start marker
//           TIMEOUT_CYCLES - idle cycles tolerated inside a frame (0 = off)
module minc_prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  minc_prog_loader_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_HI    = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_CHK   = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // Counter only needs to hold TIMEOUT_CYCLES-1: the limit is detected one
  // idle cycle before the count would reach TIMEOUT_CYCLES.
  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TMO_ON   = (TIMEOUT_CYCLES != 0);

  logic [2:0]    r_state;
  logic [7:0]    r_addr;
  logic [8:0]    r_remaining;
  logic [7:0]    r_lo;
  logic [TW-1:0] r_tmo;
  logic          r_in_ready;
  logic          r_mem_we;
  logic [7:0]    r_mem_addr;
  logic [8:0]    r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic          r_load_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;

  function automatic logic [7:0] f_sum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction
`endif

  logic w_xfer;
  logic w_tmo_state;
  logic w_tmo_hit;
  logic w_is_sync;

  // Handshake decode and timeout detection.
  always_comb begin
    w_xfer      = bus.in_valid && r_in_ready;
    w_is_sync   = (bus.in_data == SYNC_BYTE);
    w_tmo_state = (r_state == S_ADDR) || (r_state == S_COUNT) || (r_state == S_LO) ||
                  (r_state == S_HI)   || (r_state == S_CHK);
    if (TMO_ON && w_tmo_state && !w_xfer && (r_tmo == TMO_LAST)) begin
      w_tmo_hit = 1'b1;
    end else begin
      w_tmo_hit = 1'b0;
    end
  end

  // Frame FSM, word assembly, memory write port and status flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_addr      <= 8'h00;
      r_remaining <= 9'd0;
      r_lo        <= 8'h00;
      r_tmo       <= '0;
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_mem_wdata <= 9'h000;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= 8'h00;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;

      // Idle-cycle counter: clears on any accepted byte or outside a frame.
      if (w_xfer || !w_tmo_state || w_tmo_hit) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      case (r_state)
        S_IDLE, S_ERR: begin
          if (w_xfer && w_is_sync) begin
            r_state    <= S_ADDR;
            r_cpu_hold <= 1'b1;
            r_load_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
          end
        end
        S_ADDR: begin
          if (w_xfer) begin
            r_addr  <= bus.in_data;
            r_state <= S_COUNT;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= f_sum_add(r_sum, bus.in_data);
`endif
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            r_remaining <= (bus.in_data == 8'h00) ? 9'd256 : {1'b0, bus.in_data};
            r_state     <= S_LO;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= f_sum_add(r_sum, bus.in_data);
`endif
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            r_lo    <= bus.in_data;
            r_state <= S_HI;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= f_sum_add(r_sum, bus.in_data);
`endif
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            if (bus.in_data[7:1] != 7'd0) begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end else begin
              // Write strobe is launched here so it is high exactly during WR.
              r_state     <= S_WR;
              r_in_ready  <= 1'b0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= {bus.in_data[0], r_lo};
`ifdef LOADER_CHECKSUM_EN
              r_sum       <= f_sum_add(r_sum, bus.in_data);
`endif
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_WR: begin
          r_in_ready  <= 1'b1;
          r_addr      <= r_addr + 8'd1;
          r_remaining <= r_remaining - 9'd1;
          if (r_remaining == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHK;
`else
            r_state     <= S_IDLE;
            r_load_done <= 1'b1;
            r_cpu_hold  <= 1'b0;
`endif
          end else begin
            r_state <= S_LO;
          end
        end
        S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_xfer) begin
            if (f_sum_add(r_sum, bus.in_data) == 8'h00) begin
              r_state     <= S_IDLE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
`else
          // Unreachable without the checksum option.
          r_state <= S_IDLE;
`endif
        end
        default: begin
          r_state    <= S_ERR;
          r_load_err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_minc_prog_loader.sv
// tb_minc_prog_loader
// Table-driven frames with hand-computed memory writes and status, followed
// by hand-written sequences for error recovery, mid-frame reset and timeout.
module tb_minc_prog_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minc_prog_loader_if bus();

  minc_prog_loader dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] stream;   // first byte in [63:56]
    int          nb;
    int          nw;
    logic [7:0]  wa0;
    logic [8:0]  wd0;
    logic [7:0]  wa1;
    logic [8:0]  wd1;
    int          done;
    logic        err;
    logic        hold;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor: logs every memory write with its cycle number and counts pulses.
  int          cyc = 0;
  logic [16:0] wq[$];
  int          wcyc[$];
  int          n_done = 0;
  int          n_rdy_viol = 0;
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we === 1'b1) begin
      wq.push_back({bus.mem_addr, bus.mem_wdata});
      wcyc.push_back(cyc);
      if (bus.in_ready !== 1'b0) n_rdy_viol++;
    end
    if (bus.load_done === 1'b1) n_done++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b);
    int n;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    chk({tag, "_mem_we"},    {31'd0, bus.mem_we},    32'd0);
    chk({tag, "_mem_addr"},  {24'd0, bus.mem_addr},  32'd0);
    chk({tag, "_mem_wdata"}, {23'd0, bus.mem_wdata}, 32'd0);
    chk({tag, "_cpu_hold"},  {31'd0, bus.cpu_hold},  32'd1);
    chk({tag, "_load_done"}, {31'd0, bus.load_done}, 32'd0);
    chk({tag, "_load_err"},  {31'd0, bus.load_err},  32'd0);
  endtask

  function automatic vec_t mk(input logic [63:0] s, input int nb, input logic [7:0] ck,
                              input int nw, input logic [7:0] a0, input logic [8:0] d0,
                              input logic [7:0] a1, input logic [8:0] d1,
                              input int done, input logic err, input logic hold);
    vec_t t;
    t.stream = s;
    t.nb     = nb;
    if (CK) begin
      t.stream[63-8*nb -: 8] = ck;
      t.nb = nb + 1;
    end
    t.nw = nw; t.wa0 = a0; t.wd0 = d0; t.wa1 = a1; t.wd1 = d1;
    t.done = done; t.err = err; t.hold = hold;
    return t;
  endfunction

  vec_t v[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic write, address wrap, junk + in-frame SYNC as data, bad HI, bad CHK.
    v[0] = mk(64'hA5_10_02_34_01_56_00_00, 7, 8'h63, 2, 8'h10, 9'h134, 8'h11, 9'h056, 1, 1'b0, 1'b0);
    v[1] = mk(64'hA5_FF_02_01_00_02_01_00, 7, 8'hFB, 2, 8'hFF, 9'h001, 8'h00, 9'h102, 1, 1'b0, 1'b0);
    v[2] = mk(64'h33_A5_05_01_A5_00_00_00, 6, 8'h55, 1, 8'h05, 9'h0A5, 8'h00, 9'h000, 1, 1'b0, 1'b0);
    v[3] = mk(64'hA5_00_01_07_02_00_00_00, 5, 8'h00, 0, 8'h00, 9'h000, 8'h00, 9'h000, 0, 1'b1, 1'b1);
    // Trailing 00 is a wrong CHK (correct is BA) or, without checksum, idle junk.
    v[4].stream = 64'hA5_10_01_34_01_00_00_00;
    v[4].nb = 6; v[4].nw = 1; v[4].wa0 = 8'h10; v[4].wd0 = 9'h134;
    v[4].wa1 = 8'h00; v[4].wd1 = 9'h000;
    v[4].done = CK ? 0 : 1;
    v[4].err  = CK;
    v[4].hold = CK;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    idle(4);
    chk_reset_outputs("idle");

    for (int i = 0; i < 5; i++) begin
      wq.delete();
      wcyc.delete();
      n_done = 0;
      for (int j = 0; j < v[i].nb; j++) send(v[i].stream[63-8*j -: 8]);
      idle(6);
      chk($sformatf("v%0d_nwrites", i), wq.size(), v[i].nw);
      if (v[i].nw > 0) chk($sformatf("v%0d_write0", i), {15'd0, wq[0]}, {15'd0, v[i].wa0, v[i].wd0});
      if (v[i].nw > 1) begin
        chk($sformatf("v%0d_write1", i), {15'd0, wq[1]}, {15'd0, v[i].wa1, v[i].wd1});
        chk($sformatf("v%0d_word_spacing", i), wcyc[1] - wcyc[0], 32'd3);
      end
      chk($sformatf("v%0d_done_pulses", i), n_done, v[i].done);
      chk($sformatf("v%0d_load_err", i), {31'd0, bus.load_err}, {31'd0, v[i].err});
      chk($sformatf("v%0d_cpu_hold", i), {31'd0, bus.cpu_hold}, {31'd0, v[i].hold});
    end

    // Error recovery: bad HI sets load_err, a new SYNC clears it.
    send(8'hA5); send(8'h00); send(8'h01); send(8'h07); send(8'h02);
    idle(3);
    chk("err_set", {31'd0, bus.load_err}, 32'd1);
    send(8'hA5);
    idle(2);
    chk("err_cleared", {31'd0, bus.load_err}, 32'd0);
    chk("err_hold", {31'd0, bus.cpu_hold}, 32'd1);

    // Reset in the middle of a frame (FSM parked in HI).
    send(8'h20); send(8'h01); send(8'h34);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    wq.delete();
    n_done = 0;
    send(8'h01);
    idle(4);
    chk("post_reset_nwrites", wq.size(), 32'd0);
    chk("post_reset_done", n_done, 32'd0);
    chk("post_reset_err", {31'd0, bus.load_err}, 32'd0);

    // Timeout while waiting for COUNT.
    send(8'hA5); send(8'h20);
    idle(1020);
    chk("tmo_not_yet", {31'd0, bus.load_err}, 32'd0);
    idle(10);
    chk("tmo_err", {31'd0, bus.load_err}, 32'd1);
    chk("tmo_hold", {31'd0, bus.cpu_hold}, 32'd1);

    chk("ready_low_during_write", n_rdy_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
